ls_err_sched: RTL and testbench
===============================

Name: ls_err_sched

Overview:
- Scheduler that shares one Q-vs-DATA error counter among NUM_CH test-chip shift-register channels.
- Sweeps the enabled channels in ascending order. For each channel it:
  - steers the channel mux;
  - holds the counter in reset while the chip pipeline primes;
  - runs a timed compare window;
  - captures the count;
  - hands the result to the host readout over a valid/ready handshake.
- Sits between host control registers and the data generator / error counter / channel mux.

Parameters:
- NUM_CH, 8, number of test-chip channels sharing the counter.
- CH_W, 3, channel index width; must be at least clog2(NUM_CH).
- LEN_W, 24, width of the run-window length.
- LAT_W, 8, width of the pipeline-prime latency.
- CNT_W, 16, error-count width; matches the counter output.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a sweep; honoured only in IDLE.
- ABORT  in  1  level; forces IDLE from any state.
- RUN_LEN  in  LEN_W  compare-window length in cycles.
- PRIME_LAT  in  LAT_W  cycles from GEN_EN rising until chip Q is valid.
- CH_MASK  in  NUM_CH  bit i=1 means channel i is tested.
- CH_SEL  out  CH_W  channel mux select.
- GEN_EN  out  1  data generator enable.
- CNT_RST  out  1  drives the shared counter's active-high reset.
- ERR_CNT  in  CNT_W  shared counter value.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  host accepts result.
- RES_CH  out  CH_W  channel of the presented result.
- RES_CNT  out  CNT_W  error count of the presented result.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset values:
  - State IDLE; CH_SEL=0; GEN_EN=0; CNT_RST=1; RES_VALID=0; RES_CH=0; RES_CNT=0; BUSY=0; DONE=0.
  - CNT_RST idles high, so the counter stays cleared whenever no window is open.
- All outputs are registered.
- On START in IDLE, latch RUN_LEN, PRIME_LAT and CH_MASK. Host changes to these inputs mid-sweep are ignored.
- States: IDLE, SELECT, PRIME, RUN, SETTLE, REPORT, FINISH.
- IDLE --START--> SELECT.
- SELECT (1 cycle):
  - Load CH_SEL with the lowest enabled channel at or above the current index.
  - If none remains, go to FINISH.
  - Otherwise go to PRIME. CNT_RST=1 and GEN_EN=1 from entry to PRIME.
- PRIME: exactly PRIME_LAT cycles with GEN_EN=1 and CNT_RST=1. PRIME_LAT=0 means zero cycles; go straight to RUN.
- RUN:
  - Exactly max(RUN_LEN,1) cycles with CNT_RST=0 and GEN_EN=1.
  - RUN_LEN=0 behaves as 1.
- SETTLE (1 cycle): GEN_EN=0, CNT_RST=0, so the counter's final increment lands.
- REPORT:
  - On entry, RES_CNT<=ERR_CNT, RES_CH<=CH_SEL, RES_VALID<=1.
  - CNT_RST returns to 1.
  - RES_CNT and RES_CH hold stable while RES_VALID=1 and RES_READY=0.
  - On RES_VALID&RES_READY, RES_VALID<=0, advance the index by one, and go to SELECT.
  - If RES_READY is already high on the first REPORT cycle, the handshake completes in 1 cycle.
- FINISH (1 cycle): DONE=1, then IDLE. BUSY falls in the same cycle as DONE's deassertion.
- CH_MASK=0: START -> SELECT -> FINISH. DONE pulses 2 cycles after START; no results are produced.
- Index wrap: after channel NUM_CH-1 is handled, the next SELECT finds nothing and exits to FINISH. There is no wrap to 0.
- ERR_CNT wraps at CNT_W bits inside the counter. The scheduler reports the value verbatim.
- ABORT:
  - Takes priority over every transition.
  - Next cycle: IDLE, GEN_EN=0, CNT_RST=1, RES_VALID=0. No DONE.
  - START and ABORT together in IDLE: remain IDLE.
- START outside IDLE is ignored.
- Asynchronous RST mid-sweep forces the reset values immediately.

Optional Feature:
- Macro: LS_ERR_SCHED_TOTAL_EN.
- Defined:
  - Adds output TOTAL_CNT, width CNT_W+CH_W.
  - Cleared on accepted START.
  - Adds RES_CNT at each completed handshake, saturating at all-ones.
  - Value is final when DONE pulses and is held until the next START.
- Undefined: the port and its accumulator are absent. All other behaviour is identical.

Decomposition:
- Package ls_sched_pkg holds:
  - the state enum;
  - default widths (CNT_W=16, LEN_W, LAT_W);
  - a priority-find function for the next enabled channel.
- One sub-module, ls_win_timer: loadable down-counter with load, enable and a zero flag. It is instanced once and reused for PRIME and RUN.

Test Plan:
1. NUM_CH=4, CH_MASK=0101, PRIME_LAT=3, RUN_LEN=10, RES_READY=1, Q forced != DATA for channel 2 only:
   - Results are (ch0,0) then (ch2,10).
   - GEN_EN is high 13 cycles per channel.
   - CNT_RST is low exactly 10+1 cycles per channel.
   - DONE pulses once.
2. CH_MASK=0 -> DONE 2 cycles after START; RES_VALID never rises; GEN_EN stays 0.
3. RES_READY held low 20 cycles in REPORT -> RES_VALID, RES_CH and RES_CNT are stable for all 20 cycles; SELECT follows 1 cycle after READY rises.
4. ABORT asserted in cycle 5 of RUN -> next cycle IDLE, GEN_EN=0, CNT_RST=1, no DONE. A subsequent START runs a full correct sweep.
5. PRIME_LAT=0, RUN_LEN=0, all mismatches -> each channel reports a count of 1. START pulsed mid-sweep has no effect.
6. LS_ERR_SCHED_TOTAL_EN defined, CNT_W=16, 8 channels each reporting 16'hFFFF -> TOTAL_CNT=19'h7FFF8 at DONE. Forcing the accumulator near max confirms saturation at 19'h7FFFF.

Source files
------------

// File: rtl/ls_sched_pkg.sv
// Shared types and helpers for the Q-vs-DATA error-counter scheduler.
package ls_sched_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_LEN_W = 24;
  localparam int DEF_LAT_W = 8;
  localparam int MAX_CH    = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PRIME,
    S_RUN,
    S_SETTLE,
    S_REPORT,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] ch;
  } next_ch_t;

  // Lowest set mask bit at or above start; descending scan lets the lowest hit win.
  function automatic next_ch_t find_next(input logic [MAX_CH-1:0] mask,
                                         input logic [5:0]        start);
    next_ch_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (6'(i) >= start)) begin
        r.found = 1'b1;
        r.ch    = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ls_win_timer.sv
// Loadable down-counter with a zero flag; times both the prime and run windows.
module ls_win_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ls_err_sched.sv
// Sweeps enabled channels through prime / run / settle / report on one shared error counter.
// Optional running total of reported counts: define LS_ERR_SCHED_TOTAL_EN.
module ls_err_sched
  import ls_sched_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 3,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int LAT_W  = DEF_LAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [LEN_W-1:0]  RUN_LEN,
  input  logic [LAT_W-1:0]  PRIME_LAT,
  input  logic [NUM_CH-1:0] CH_MASK,
  output logic [CH_W-1:0]   CH_SEL,
  output logic              GEN_EN,
  output logic              CNT_RST,
  input  logic [CNT_W-1:0]  ERR_CNT,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [CH_W-1:0]   RES_CH,
  output logic [CNT_W-1:0]  RES_CNT,
  output logic              BUSY,
`ifdef LS_ERR_SCHED_TOTAL_EN
  output logic [CNT_W+CH_W-1:0] TOTAL_CNT,
`endif
  output logic              DONE
);

  localparam int TMR_W = (LEN_W > LAT_W) ? LEN_W : LAT_W;

  state_t            r_state;
  logic [LEN_W-1:0]  r_run_len;
  logic [LAT_W-1:0]  r_prime_lat;
  logic [NUM_CH-1:0] r_mask;
  logic [CH_W:0]     r_idx;

  next_ch_t          w_nxt;
  logic [TMR_W-1:0]  w_run_load;
  logic [TMR_W-1:0]  w_prime_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_load;
  logic              w_tmr_en;
  logic              w_tmr_zero;

  assign w_nxt        = find_next(MAX_CH'(r_mask), 6'(r_idx));
  // Timer counts N-1 down to 0, so a window of N cycles ends on the zero flag.
  assign w_run_load   = (r_run_len == '0) ? '0 : (TMR_W'(r_run_len) - TMR_W'(1));
  assign w_prime_load = TMR_W'(r_prime_lat) - TMR_W'(1);

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = w_run_load;
    w_tmr_en   = 1'b0;
    case (r_state)
      S_SELECT: begin
        if (w_nxt.found) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = (r_prime_lat == '0) ? w_run_load : w_prime_load;
        end
      end
      S_PRIME: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = w_run_load;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      S_RUN:   w_tmr_en = 1'b1;
      default: ;
    endcase
  end

  ls_win_timer #(
    .W(TMR_W)
  ) u_win_timer (
    .clk       (CLK),
    .rst       (RST),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .i_en      (w_tmr_en),
    .o_zero    (w_tmr_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_run_len   <= '0;
      r_prime_lat <= '0;
      r_mask      <= '0;
      r_idx       <= '0;
      CH_SEL      <= '0;
      GEN_EN      <= 1'b0;
      CNT_RST     <= 1'b1;
      RES_VALID   <= 1'b0;
      RES_CH      <= '0;
      RES_CNT     <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else if (ABORT) begin
      r_state   <= S_IDLE;
      GEN_EN    <= 1'b0;
      CNT_RST   <= 1'b1;
      RES_VALID <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_run_len   <= RUN_LEN;
            r_prime_lat <= PRIME_LAT;
            r_mask      <= CH_MASK;
            r_idx       <= '0;
            BUSY        <= 1'b1;
            r_state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (!w_nxt.found) begin
            DONE    <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            CH_SEL <= CH_W'(w_nxt.ch);
            GEN_EN <= 1'b1;
            if (r_prime_lat == '0) begin
              CNT_RST <= 1'b0;
              r_state <= S_RUN;
            end else begin
              CNT_RST <= 1'b1;
              r_state <= S_PRIME;
            end
          end
        end
        S_PRIME: begin
          if (w_tmr_zero) begin
            CNT_RST <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Counter stays out of reset one more cycle so its last increment lands.
          if (w_tmr_zero) begin
            GEN_EN  <= 1'b0;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          RES_CNT   <= ERR_CNT;
          RES_CH    <= CH_SEL;
          RES_VALID <= 1'b1;
          CNT_RST   <= 1'b1;
          r_state   <= S_REPORT;
        end
        S_REPORT: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            r_idx     <= {1'b0, CH_SEL} + 1'b1;
            r_state   <= S_SELECT;
          end
        end
        S_FINISH: begin
          BUSY    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LS_ERR_SCHED_TOTAL_EN
  logic                  w_start;
  logic                  w_accept;
  logic [CNT_W+CH_W:0]   w_sum;

  assign w_start  = START && !ABORT && (r_state == S_IDLE);
  assign w_accept = !ABORT && (r_state == S_REPORT) && RES_VALID && RES_READY;
  assign w_sum    = {1'b0, TOTAL_CNT} + (CNT_W+CH_W+1)'(RES_CNT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TOTAL_CNT <= '0;
    end else if (w_start) begin
      TOTAL_CNT <= '0;
    end else if (w_accept) begin
      TOTAL_CNT <= w_sum[CNT_W+CH_W] ? '1 : w_sum[CNT_W+CH_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_ls_err_sched.sv
// Directed bench for ls_err_sched with a behavioural shared error counter.
module tb_ls_err_sched;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int LEN_W  = 24;
  localparam int LAT_W  = 8;
  localparam int CNT_W  = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic              ABORT = 1'b0;
  logic [LEN_W-1:0]  RUN_LEN = '0;
  logic [LAT_W-1:0]  PRIME_LAT = '0;
  logic [NUM_CH-1:0] CH_MASK = '0;
  logic [CH_W-1:0]   CH_SEL;
  logic              GEN_EN;
  logic              CNT_RST;
  logic [CNT_W-1:0]  ERR_CNT;
  logic              RES_VALID;
  logic              RES_READY = 1'b0;
  logic [CH_W-1:0]   RES_CH;
  logic [CNT_W-1:0]  RES_CNT;
  logic              BUSY;
  logic              DONE;
`ifdef LS_ERR_SCHED_TOTAL_EN
  logic [CNT_W+CH_W-1:0] TOTAL_CNT;
`endif

  ls_err_sched #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .LEN_W(LEN_W), .LAT_W(LAT_W), .CNT_W(CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .ABORT    (ABORT),
    .RUN_LEN  (RUN_LEN),
    .PRIME_LAT(PRIME_LAT),
    .CH_MASK  (CH_MASK),
    .CH_SEL   (CH_SEL),
    .GEN_EN   (GEN_EN),
    .CNT_RST  (CNT_RST),
    .ERR_CNT  (ERR_CNT),
    .RES_VALID(RES_VALID),
    .RES_READY(RES_READY),
    .RES_CH   (RES_CH),
    .RES_CNT  (RES_CNT),
    .BUSY     (BUSY),
`ifdef LS_ERR_SCHED_TOTAL_EN
    .TOTAL_CNT(TOTAL_CNT),
`endif
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  // Shared counter: counts mismatching cycles of the selected channel while out of reset.
  logic [NUM_CH-1:0] mism = '0;
  logic              err_ovr = 1'b0;
  logic [CNT_W-1:0]  err_q = '0;

  always @(posedge CLK) begin
    if (CNT_RST) err_q <= '0;
    else if (mism[CH_SEL]) err_q <= err_q + 1'b1;
  end

  assign ERR_CNT = err_ovr ? {CNT_W{1'b1}} : err_q;

  int n_chk = 0;
  int n_err = 0;
  int n_gen, n_crl, n_done, n_res, n_vld, done_at;
  logic [CH_W-1:0]  res_ch_q  [8];
  logic [CNT_W-1:0] res_cnt_q [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Samples one cycle at a time until DONE, gathering per-sweep statistics.
  task automatic run_sweep(input int budget);
    n_gen = 0; n_crl = 0; n_done = 0; n_res = 0; n_vld = 0; done_at = -1;
    for (int k = 0; k < budget; k++) begin
      if (GEN_EN) n_gen++;
      if (!CNT_RST) n_crl++;
      if (RES_VALID) n_vld++;
      if (RES_VALID && RES_READY && n_res < 8) begin
        res_ch_q[n_res]  = RES_CH;
        res_cnt_q[n_res] = RES_CNT;
        n_res++;
      end
      if (DONE) begin
        n_done++;
        done_at = k + 1;
        break;
      end
      tick();
    end
    if (done_at < 0) chk("sweep_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    int  n;
    logic stable;

    // Reset state
    tick(); tick();
    chk("rst_busy",    BUSY, 0);
    chk("rst_done",    DONE, 0);
    chk("rst_gen_en",  GEN_EN, 0);
    chk("rst_cnt_rst", CNT_RST, 1);
    chk("rst_valid",   RES_VALID, 0);
    chk("rst_ch_sel",  CH_SEL, 0);
    chk("rst_res_ch",  RES_CH, 0);
    chk("rst_res_cnt", RES_CNT, 0);
    RST = 1'b0;
    tick();

    // Two channels, ch2 always mismatching; host inputs change mid-sweep
    CH_MASK = 4'b0101; PRIME_LAT = 8'd3; RUN_LEN = 24'd10; RES_READY = 1'b1; mism = 4'b0100;
    pulse_start();
    chk("t1_busy", BUSY, 1);
    CH_MASK = 4'b1111; PRIME_LAT = 8'd1; RUN_LEN = 24'd7;
    run_sweep(400);
    chk("t1_n_res",    n_res, 2);
    chk("t1_res0_ch",  res_ch_q[0], 0);
    chk("t1_res0_cnt", res_cnt_q[0], 0);
    chk("t1_res1_ch",  res_ch_q[1], 2);
    chk("t1_res1_cnt", res_cnt_q[1], 10);
    chk("t1_gen_cyc",  n_gen, 26);
    chk("t1_crl_cyc",  n_crl, 22);
    chk("t1_done_n",   n_done, 1);
`ifdef LS_ERR_SCHED_TOTAL_EN
    chk("t1_total", TOTAL_CNT, 10);
`endif
    tick();
    chk("t1_done_fall", DONE, 0);
    chk("t1_busy_fall", BUSY, 0);

    // Empty mask
    CH_MASK = 4'b0000;
    pulse_start();
    run_sweep(20);
    chk("t2_done_at", done_at, 2);
    chk("t2_no_valid", n_vld, 0);
    chk("t2_no_gen", n_gen, 0);
    tick();

    // Host stalls the result for 20 cycles
    CH_MASK = 4'b0010; PRIME_LAT = 8'd2; RUN_LEN = 24'd5; RES_READY = 1'b0; mism = 4'b0010;
    pulse_start();
    w = 0;
    while (!RES_VALID && w < 50) begin tick(); w++; end
    chk("t3_valid_seen", RES_VALID, 1);
    chk("t3_res_ch", RES_CH, 1);
    chk("t3_res_cnt", RES_CNT, 5);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (RES_VALID !== 1'b1 || RES_CH !== 2'd1 || RES_CNT !== 16'd5) stable = 1'b0;
    end
    chk("t3_stable", stable, 1);
    RES_READY = 1'b1;
    tick();
    chk("t3_valid_drop", RES_VALID, 0);
    chk("t3_busy_hold", BUSY, 1);
    tick();
    chk("t3_done_after_select", DONE, 1);
    tick();
    chk("t3_idle", BUSY, 0);

    // Abort in the fifth run cycle
    CH_MASK = 4'b0101; PRIME_LAT = 8'd3; RUN_LEN = 24'd10; mism = 4'b0100;
    pulse_start();
    w = 0;
    while (CNT_RST && w < 50) begin tick(); w++; end
    chk("t4_run_seen", CNT_RST, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_in_run", GEN_EN, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("t4_gen_en", GEN_EN, 0);
    chk("t4_cnt_rst", CNT_RST, 1);
    chk("t4_busy", BUSY, 0);
    chk("t4_valid", RES_VALID, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE) n++;
      tick();
    end
    chk("t4_no_done", n, 0);
    START = 1'b1; ABORT = 1'b1;
    tick();
    START = 1'b0; ABORT = 1'b0;
    chk("t4_start_abort_idle", BUSY, 0);
    tick();
    chk("t4_still_idle", BUSY, 0);
    pulse_start();
    run_sweep(400);
    chk("t4_n_res", n_res, 2);
    chk("t4_res0", {res_ch_q[0], res_cnt_q[0]}, {2'd0, 16'd0});
    chk("t4_res1", {res_ch_q[1], res_cnt_q[1]}, {2'd2, 16'd10});
    chk("t4_gen_cyc", n_gen, 26);
    tick();

    // Zero prime and run lengths, all channels mismatching, stray START mid-sweep
    CH_MASK = 4'b1111; PRIME_LAT = 8'd0; RUN_LEN = 24'd0; mism = 4'b1111;
    pulse_start();
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    run_sweep(400);
    chk("t5_n_res", n_res, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_res%0d_ch", i), res_ch_q[i], i);
      chk($sformatf("t5_res%0d_cnt", i), res_cnt_q[i], 1);
    end
    chk("t5_done_n", n_done, 1);
    tick();

    // Asynchronous reset mid-sweep
    CH_MASK = 4'b0100; PRIME_LAT = 8'd3; RUN_LEN = 24'd10;
    pulse_start();
    tick(); tick();
    chk("t6_pre_gen", GEN_EN, 1);
    chk("t6_pre_sel", CH_SEL, 2);
    #2 RST = 1'b1;
    #1;
    chk("t6_busy", BUSY, 0);
    chk("t6_gen_en", GEN_EN, 0);
    chk("t6_cnt_rst", CNT_RST, 1);
    chk("t6_ch_sel", CH_SEL, 0);
    RST = 1'b0;
    tick();
    tick();
    chk("t6_stays_idle", BUSY, 0);

`ifdef LS_ERR_SCHED_TOTAL_EN
    // Every channel reports all-ones
    CH_MASK = 4'b1111; PRIME_LAT = 8'd1; RUN_LEN = 24'd1; err_ovr = 1'b1;
    pulse_start();
    chk("t7_total_clear", TOTAL_CNT, 0);
    run_sweep(400);
    chk("t7_total", TOTAL_CNT, 18'h3FFFC);
    err_ovr = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
